// File: rtl/of_scheduler.sv
// rtl/of_scheduler.sv - issue controller in front of operand_fetch
// One-entry issue slot with a 16-entry scoreboard interlock and a registered execute output.
module of_scheduler #(
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic [31:0]        in_pc,
    input  logic               flush,
    output logic               of_p,
    output logic               of_isst,
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic [31:0]        ex_instr,
    output logic [31:0]        ex_pc,
    input  logic               wb_valid,
    input  logic [3:0]         wb_rd,
    output logic [15:0]        busy,
    output logic [STALL_W-1:0] stall_count
);

    localparam logic [4:0] OP_ASR  = 5'd12;
    localparam logic [4:0] OP_LSL  = 5'd10;
    localparam logic [4:0] OP_OR   = 5'd7;
    localparam logic [4:0] OP_CMP  = 5'd5;
    localparam logic [4:0] OP_MOD  = 5'd4;
    localparam logic [4:0] OP_LD   = 5'd14;
    localparam logic [4:0] OP_ST   = 5'd15;
    localparam logic [4:0] OP_CALL = 5'd19;
    localparam logic [4:0] OP_RET  = 5'd20;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Each decode helper returns {used, register}.
    function automatic logic [4:0] dec_src1(input logic [31:0] instr);
        logic [4:0] op;
        op = instr[31:27];
        if (op == OP_RET)
            return {1'b1, 4'd15};
        if (op <= OP_OR || (op >= OP_LSL && op <= OP_ASR) || op == OP_LD || op == OP_ST)
            return {1'b1, instr[21:18]};
        return 5'd0;
    endfunction

    function automatic logic [4:0] dec_src2(input logic [31:0] instr);
        logic [4:0] op;
        op = instr[31:27];
        if (op == OP_ST)
            return {1'b1, instr[25:22]};
        if (op <= OP_ASR && !instr[26])
            return {1'b1, instr[17:14]};
        return 5'd0;
    endfunction

    function automatic logic [4:0] dec_dst(input logic [31:0] instr);
        logic [4:0] op;
        op = instr[31:27];
        if (op <= OP_MOD || (op > OP_CMP && op <= OP_ASR) || op == OP_LD)
            return {1'b1, instr[25:22]};
        if (op == OP_CALL)
            return {1'b1, 4'd15};
        return 5'd0;
    endfunction

    slot_state_t        r_slot_state;
    slot_state_t        w_slot_state_next;
    logic [31:0]        r_slot_instr;
    logic [31:0]        r_slot_pc;
    logic               r_ex_valid;
    logic [31:0]        r_ex_instr;
    logic [31:0]        r_ex_pc;
    logic [15:0]        r_busy;
    logic [15:0]        w_busy_next;
    logic [STALL_W-1:0] r_stall;

    logic        w_slot_full;
    logic [4:0]  w_s1;
    logic [4:0]  w_s2;
    logic [4:0]  w_dst;
    logic [4:0]  w_ex_dst;
    logic [15:0] w_pending;
    logic        w_hazard;
    logic        w_issue;
    logic        w_in_ready;
    logic        w_in_hs;
    logic        w_ex_hs;

    assign w_slot_full = (r_slot_state == SLOT_FULL);
    assign w_s1        = dec_src1(r_slot_instr);
    assign w_s2        = dec_src2(r_slot_instr);
    assign w_dst       = dec_dst(r_slot_instr);
    assign w_ex_dst    = dec_dst(r_ex_instr);

    // The instruction sitting in execute has not yet set its busy bit, so it counts as pending too.
    always_comb begin
        w_pending = r_busy;
        if (r_ex_valid && w_ex_dst[4])
            w_pending[w_ex_dst[3:0]] = 1'b1;
    end

    assign w_hazard = (w_s1[4]  && w_pending[w_s1[3:0]])
                    | (w_s2[4]  && w_pending[w_s2[3:0]])
                    | (w_dst[4] && w_pending[w_dst[3:0]]);

    assign w_issue    = w_slot_full & ~w_hazard & ~flush & (~r_ex_valid | ex_ready);
    assign w_in_ready = (~w_slot_full | w_issue) & ~flush;
    assign w_in_hs    = in_valid & w_in_ready;
    assign w_ex_hs    = r_ex_valid & ex_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_slot_state <= SLOT_EMPTY;
        else
            r_slot_state <= w_slot_state_next;
    end

    always_comb begin
        w_slot_state_next = r_slot_state;
        if (flush)
            w_slot_state_next = SLOT_EMPTY;
        else if (w_in_hs)
            w_slot_state_next = SLOT_FULL;
        else if (w_issue)
            w_slot_state_next = SLOT_EMPTY;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot_instr <= 32'd0;
            r_slot_pc    <= 32'd0;
        end else if (w_in_hs) begin
            r_slot_instr <= in_instr;
            r_slot_pc    <= in_pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ex_valid <= 1'b0;
            r_ex_instr <= 32'd0;
            r_ex_pc    <= 32'd0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
        end else if (w_issue) begin
            r_ex_valid <= 1'b1;
            r_ex_instr <= r_slot_instr;
            r_ex_pc    <= r_slot_pc;
        end else if (ex_ready) begin
            r_ex_valid <= 1'b0;
        end
    end

    // Set is applied after clear so a same-register collision leaves the bit set.
    always_comb begin
        w_busy_next = r_busy;
        if (wb_valid)
            w_busy_next[wb_rd] = 1'b0;
        if (w_ex_hs && w_ex_dst[4])
            w_busy_next[w_ex_dst[3:0]] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_busy <= 16'd0;
        else
            r_busy <= w_busy_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_stall <= '0;
        else if (w_slot_full && !w_issue && !flush && !(&r_stall))
            r_stall <= r_stall + {{(STALL_W-1){1'b0}}, 1'b1};
    end

    assign in_ready    = w_in_ready;
    assign of_p        = w_slot_full & (r_slot_instr[31:27] == OP_RET);
    assign of_isst     = w_slot_full & (r_slot_instr[31:27] == OP_ST);
    assign ex_valid    = r_ex_valid;
    assign ex_instr    = r_ex_instr;
    assign ex_pc       = r_ex_pc;
    assign busy        = r_busy;
    assign stall_count = r_stall;

endmodule

// File: tb/tb_of_scheduler.sv
// tb/tb_of_scheduler.sv - self-checking bench for of_scheduler
module tb_of_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        of_p;
    logic        of_isst;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_instr;
    logic [31:0] ex_pc;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [15:0] busy;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    of_scheduler #(.STALL_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .flush       (flush),
        .of_p        (of_p),
        .of_isst     (of_isst),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_instr    (ex_instr),
        .ex_pc       (ex_pc),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .busy        (busy),
        .stall_count (stall_count)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } xact_t;

    typedef struct {
        logic        iv;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        wv;
        logic [3:0]  wr;
        logic        e_in_ready;
        logic        e_of_p;
        logic        e_of_isst;
        logic        e_ex_valid;
        logic [15:0] e_busy;
        logic [15:0] e_stall;
    } vec_t;

    xact_t exp_q[$];
    vec_t  vecs[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int op, input bit imm, input int rd, input int rs1, input int rs2);
        return {op[4:0], imm, rd[3:0], rs1[3:0], rs2[3:0], 14'h0};
    endfunction

    function automatic vec_t mk(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                                input logic wv, input logic [3:0] wr,
                                input logic eir, input logic eop, input logic eis, input logic eev,
                                input logic [15:0] eb, input logic [15:0] es);
        vec_t v;
        v.iv = iv; v.instr = ins; v.pc = pc; v.wv = wv; v.wr = wr;
        v.e_in_ready = eir; v.e_of_p = eop; v.e_of_isst = eis; v.e_ex_valid = eev;
        v.e_busy = eb; v.e_stall = es;
        return v;
    endfunction

    task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] pc, input logic er,
                         input logic wv, input logic [3:0] wr, input logic fl);
        in_valid = iv; in_instr = ins; in_pc = pc; ex_ready = er;
        wb_valid = wv; wb_rd = wr; flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: handshakes seen just before the rising edge they complete on.
    always @(negedge clk) begin
        xact_t e;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (ex_valid && ex_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_unexpected: got instr 0x%08h, expected nothing", ex_instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_instr", ex_instr, e.instr);
                    chk("sb_pc", ex_pc, e.pc);
                end
            end
            if (flush)
                exp_q.delete();
            if (in_valid && in_ready)
                exp_q.push_back('{in_instr, in_pc});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] i_add1, i_sub4, i_subraw, i_mov7, i_st7, i_call, i_ret;
        logic [31:0] i_a, i_b, i_c, i_d, i_e, i_f;
        i_add1   = enc(0, 0, 1, 2, 3);
        i_sub4   = enc(1, 0, 4, 5, 6);
        i_subraw = enc(1, 0, 2, 1, 3);
        i_mov7   = enc(9, 1, 7, 0, 0);
        i_st7    = enc(15, 1, 7, 2, 0);
        i_call   = enc(19, 0, 0, 0, 0);
        i_ret    = enc(20, 0, 0, 0, 0);
        i_a      = enc(0, 0, 1, 2, 3);
        i_b      = enc(0, 0, 4, 5, 6);
        i_c      = enc(0, 0, 5, 6, 7);
        i_d      = enc(0, 0, 8, 9, 10);
        i_e      = enc(0, 0, 3, 1, 2);
        i_f      = enc(15, 0, 3, 4, 0);

        //                iv ins       pc        wv wr   rdy p  st exv busy      stall
        vecs.push_back(mk(0, 0,        0,        0, 0,   1, 0, 0, 0, 16'h0000, 0));
        vecs.push_back(mk(1, i_add1,   32'h100,  0, 0,   1, 0, 0, 0, 16'h0000, 0));
        vecs.push_back(mk(1, i_sub4,   32'h104,  0, 0,   1, 0, 0, 0, 16'h0000, 0));
        vecs.push_back(mk(0, 0,        0,        0, 0,   1, 0, 0, 1, 16'h0000, 0));
        vecs.push_back(mk(0, 0,        0,        0, 0,   1, 0, 0, 1, 16'h0002, 0));
        vecs.push_back(mk(0, 0,        0,        0, 0,   1, 0, 0, 0, 16'h0012, 0));
        vecs.push_back(mk(0, 0,        0,        1, 1,   1, 0, 0, 0, 16'h0012, 0));
        vecs.push_back(mk(0, 0,        0,        1, 4,   1, 0, 0, 0, 16'h0010, 0));
        vecs.push_back(mk(0, 0,        0,        0, 0,   1, 0, 0, 0, 16'h0000, 0));
        vecs.push_back(mk(1, i_add1,   32'h200,  0, 0,   1, 0, 0, 0, 16'h0000, 0));
        vecs.push_back(mk(1, i_subraw, 32'h204,  0, 0,   1, 0, 0, 0, 16'h0000, 0));
        vecs.push_back(mk(0, 0,        0,        0, 0,   0, 0, 0, 1, 16'h0000, 0));
        vecs.push_back(mk(0, 0,        0,        0, 0,   0, 0, 0, 0, 16'h0002, 1));
        vecs.push_back(mk(0, 0,        0,        1, 1,   0, 0, 0, 0, 16'h0002, 2));
        vecs.push_back(mk(0, 0,        0,        0, 0,   1, 0, 0, 0, 16'h0000, 3));
        vecs.push_back(mk(0, 0,        0,        0, 0,   1, 0, 0, 1, 16'h0000, 3));
        vecs.push_back(mk(0, 0,        0,        1, 2,   1, 0, 0, 0, 16'h0004, 3));
        vecs.push_back(mk(1, i_mov7,   32'h300,  0, 0,   1, 0, 0, 0, 16'h0000, 3));
        vecs.push_back(mk(1, i_st7,    32'h304,  0, 0,   1, 0, 0, 0, 16'h0000, 3));
        vecs.push_back(mk(0, 0,        0,        0, 0,   0, 0, 1, 1, 16'h0000, 3));
        vecs.push_back(mk(0, 0,        0,        0, 0,   0, 0, 1, 0, 16'h0080, 4));
        vecs.push_back(mk(0, 0,        0,        1, 7,   0, 0, 1, 0, 16'h0080, 5));
        vecs.push_back(mk(0, 0,        0,        0, 0,   1, 0, 1, 0, 16'h0000, 6));
        vecs.push_back(mk(0, 0,        0,        0, 0,   1, 0, 0, 1, 16'h0000, 6));
        vecs.push_back(mk(1, i_call,   32'h400,  0, 0,   1, 0, 0, 0, 16'h0000, 6));
        vecs.push_back(mk(1, i_ret,    32'h404,  0, 0,   1, 0, 0, 0, 16'h0000, 6));
        vecs.push_back(mk(0, 0,        0,        0, 0,   0, 1, 0, 1, 16'h0000, 6));
        vecs.push_back(mk(0, 0,        0,        0, 0,   0, 1, 0, 0, 16'h8000, 7));
        vecs.push_back(mk(0, 0,        0,        1, 15,  0, 1, 0, 0, 16'h8000, 8));
        vecs.push_back(mk(0, 0,        0,        0, 0,   1, 1, 0, 0, 16'h0000, 9));
        vecs.push_back(mk(0, 0,        0,        0, 0,   1, 0, 0, 1, 16'h0000, 9));

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_of_p", of_p, 0);
        chk("rst_of_isst", of_isst, 0);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_instr", ex_instr, 0);
        chk("rst_ex_pc", ex_pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall_count, 0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].iv, vecs[i].instr, vecs[i].pc, 1'b1, vecs[i].wv, vecs[i].wr, 1'b0);
            #1;
            chk($sformatf("row%0d_in_ready", i), in_ready, vecs[i].e_in_ready);
            chk($sformatf("row%0d_of_p", i), of_p, vecs[i].e_of_p);
            chk($sformatf("row%0d_of_isst", i), of_isst, vecs[i].e_of_isst);
            chk($sformatf("row%0d_ex_valid", i), ex_valid, vecs[i].e_ex_valid);
            chk($sformatf("row%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("row%0d_stall", i), stall_count, vecs[i].e_stall);
            step();
        end

        // Backpressure: two queued, execute stalled for three cycles.
        drive(1, i_a, 32'h500, 0, 0, 0, 0); #1; step();
        drive(1, i_b, 32'h504, 0, 0, 0, 0); #1;
        chk("bp_accept_b", in_ready, 1);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0); #1;
            chk($sformatf("bp%0d_ex_valid", k), ex_valid, 1);
            chk($sformatf("bp%0d_ex_instr", k), ex_instr, i_a);
            chk($sformatf("bp%0d_ex_pc", k), ex_pc, 32'h500);
            chk($sformatf("bp%0d_in_ready", k), in_ready, 0);
            step();
        end
        drive(0, 0, 0, 1, 0, 0, 0); #1;
        chk("bp_release_instr", ex_instr, i_a);
        step();
        drive(0, 0, 0, 1, 0, 0, 0); #1;
        chk("bp_second_valid", ex_valid, 1);
        chk("bp_second_instr", ex_instr, i_b);
        step();
        drive(0, 0, 0, 1, 0, 0, 0); #1;
        chk("bp_busy", busy, 16'h0012);
        chk("bp_stall", stall_count, 12);
        chk("bp_ex_empty", ex_valid, 0);
        step();
        drive(0, 0, 0, 1, 1, 1, 0); #1; step();
        drive(0, 0, 0, 1, 1, 4, 0); #1; step();
        drive(0, 0, 0, 1, 0, 0, 0); #1;
        chk("bp_busy_cleared", busy, 0);
        step();

        // Flush with execute handshaking: its busy bit must still be set.
        drive(1, i_a, 32'h600, 0, 0, 0, 0); #1; step();
        drive(1, i_b, 32'h604, 0, 0, 0, 0); #1; step();
        drive(0, 0, 0, 1, 0, 0, 1); #1;
        chk("fl1_in_ready", in_ready, 0);
        chk("fl1_ex_valid", ex_valid, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0); #1;
        chk("fl1_ex_empty", ex_valid, 0);
        chk("fl1_slot_empty", in_ready, 1);
        chk("fl1_busy_set", busy, 16'h0002);
        chk("fl1_stall", stall_count, 12);
        step();

        // Flush with execute stalled: nothing handshakes, busy untouched.
        drive(1, i_c, 32'h700, 0, 0, 0, 0); #1; step();
        drive(1, i_d, 32'h704, 0, 0, 0, 0); #1; step();
        drive(0, 0, 0, 0, 0, 0, 1); #1;
        chk("fl2_in_ready", in_ready, 0);
        chk("fl2_ex_valid", ex_valid, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0); #1;
        chk("fl2_ex_empty", ex_valid, 0);
        chk("fl2_slot_empty", in_ready, 1);
        chk("fl2_busy_kept", busy, 16'h0002);
        chk("fl2_stall", stall_count, 12);
        step();
        drive(0, 0, 0, 1, 1, 1, 0); #1; step();

        // Set and clear of r3 in the same cycle.
        drive(1, i_e, 32'h800, 1, 0, 0, 0); #1; step();
        drive(0, 0, 0, 1, 0, 0, 0); #1;
        chk("col_issue", in_ready, 1);
        step();
        drive(0, 0, 0, 1, 1, 3, 0); #1;
        chk("col_ex_valid", ex_valid, 1);
        step();
        drive(0, 0, 0, 1, 0, 0, 0); #1;
        chk("col_busy", busy, 16'h0008);
        chk("sb_drained", exp_q.size(), 0);
        step();

        // Reset in the middle of a store stalled on r3.
        drive(1, i_f, 32'h900, 1, 0, 0, 0); #1; step();
        drive(0, 0, 0, 1, 0, 0, 0); #1;
        chk("rs_stalled", in_ready, 0);
        chk("rs_of_isst", of_isst, 1);
        chk("rs_stall_a", stall_count, 12);
        step();
        drive(0, 0, 0, 1, 0, 0, 0); #1;
        chk("rs_stall_b", stall_count, 13);
        chk("rs_ex_instr_held", ex_instr, i_e);
        #2;
        reset = 1'b1;
        #1;
        chk("rs_in_ready", in_ready, 1);
        chk("rs_of_isst_clr", of_isst, 0);
        chk("rs_of_p_clr", of_p, 0);
        chk("rs_ex_valid", ex_valid, 0);
        chk("rs_ex_instr", ex_instr, 0);
        chk("rs_ex_pc", ex_pc, 0);
        chk("rs_busy", busy, 0);
        chk("rs_stall", stall_count, 0);
        step();
        reset = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/of_scheduler.md
# of_scheduler

Issue controller in front of `operand_fetch` in the 32-bit pipeline. Accepts fetched instructions through a valid/ready handshake and decodes their source and destination registers. Interlocks against in-flight register writes using a 16-entry scoreboard, then hands hazard-free instructions to the execute stage through a registered valid/ready output. Drives the `p` (ret) and `isst` (store) selects that steer `operand_fetch`'s register-file read addresses.

## Interface
- `STALL_W`, 16: width of the saturating stall counter.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `in_valid` input 1: fetch offers an instruction.
- `in_ready` output 1: slot can accept this cycle.
- `in_instr` input 32: instruction word.
- `in_pc` input 32: its PC.
- `flush` input 1: taken branch; kill all unissued work.
- `of_p` output 1: to `operand_fetch.p`; 1 when the slot holds `ret`.
- `of_isst` output 1: to `operand_fetch.isst`; 1 when the slot holds `st`.
- `ex_valid` output 1: execute register holds an instruction.
- `ex_ready` input 1: execute accepts.
- `ex_instr` output 32: instruction registered into execute.
- `ex_pc` output 32: PC registered into execute.
- `wb_valid` input 1: writeback retires a register write.
- `wb_rd` input 4: register being written.
- `busy` output 16: scoreboard, bit n = write to rN pending.
- `stall_count` output STALL_W: cycles the slot was full but did not issue; saturates at all-ones.

## Operation
- **Decode**, from the slot instruction: `op` is [31:27], `i` is [26], `rd` is [25:22], `rs1` is [21:18], `rs2f` is [17:14].
  - Opcodes: add 0, sub 1, mul 2, div 3, mod 4, cmp 5, and 6, or 7, not 8, mov 9, lsl 10, lsr 11, asr 12, nop 13, ld 14, st 15, beq 16, bgt 17, b 18, call 19, ret 20.
  - Opcodes 21–31 decode as nop.
- **Source 1**:
  - `ret` reads r15.
  - Opcodes 0–7, 10–12, 14 and 15 read `rs1`.
  - All other opcodes have no source 1.
- **Source 2**:
  - `st` reads `rd`, regardless of `i`.
  - Opcodes 0–12 with `i`=0 read `rs2f`.
  - All other cases have no source 2.
- **Destination**:
  - Opcodes 0–4, 6–12 and 14 write `rd`.
  - `call` writes r15.
  - All other opcodes write nothing.
- **Hazard** holds when any used source, or the destination (WAW), is pending. A register R is pending if either:
  - `busy[R]` is set, or
  - `ex_valid` is high and the execute-register instruction's destination is R.
- **State**: the slot is EMPTY or FULL; the execute register is EMPTY or FULL.
- **Issue**: `issue = slot FULL & !hazard & !flush & (!ex_valid | ex_ready)`. On issue, the slot instruction and PC move to the execute register.
- **Slot acceptance**: `in_ready = (slot EMPTY | issue) & !flush`. A handshake loads the slot.
- **Scoreboard set**: on an execute handshake (`ex_valid & ex_ready`) whose instruction has a destination, set `busy[dst]`.
- **Scoreboard clear**: `wb_valid` clears `busy[wb_rd]`. If set and clear hit the same register in the same cycle, set wins.
- **Flush**:
  - Next edge: slot EMPTY and `ex_valid` 0.
  - An execute handshake completing in the flush cycle still counts and sets `busy`.
  - The scoreboard is otherwise untouched.
  - `stall_count` does not increment in the flush cycle.
- **Stall counter**: increments each cycle the slot is FULL and `issue` is 0.
- **`of_p` / `of_isst`**: combinational from the slot; both 0 when the slot is EMPTY.

## Timing
- **Reset values**:
  - Slot EMPTY, execute register EMPTY.
  - `ex_valid` 0, `ex_instr` 0, `ex_pc` 0.
  - `busy` 0, `stall_count` 0.
  - `in_ready` 1, `of_p` 0, `of_isst` 0.
- **Reset mid-operation** discards the slot, the execute register and the scoreboard immediately (asynchronous).
- **Latency**: `in_valid` handshake at edge N gives slot FULL after N. With no hazard, `ex_valid`=1 after edge N+1.
- **Throughput**: 1 instruction per cycle while there are no hazards and `ex_ready`=1.
- **Dependent back-to-back producer→consumer**: the consumer cannot issue before the cycle after the producer's `busy` bit clears. A clear at edge M allows issue at edge M+1.
- **Output stability**: `ex_instr` and `ex_pc` hold stable while `ex_valid` is 1 and `ex_ready` is 0.
- **Held instruction**: `in_instr` is sampled only on a handshake; the slot holds it while FULL.

## Test plan
- **Stream**: add r1,r2,r3 then sub r4,r5,r6, with `ex_ready`=1.
  - `ex_valid` high on consecutive cycles starting 2 cycles after the first handshake.
  - `busy` = 0x0002 then 0x0012.
  - `stall_count` stays 0.
- **RAW**: add r1,… then sub r2,r1,r3.
  - sub stalls until `wb_valid`/`wb_rd`=1.
  - sub issues the cycle after the clear.
  - `stall_count` equals the number of stalled cycles.
- **Store and ret**:
  - st r7,[r2]: `of_isst`=1; stalls while `busy[7]`=1.
  - ret: `of_p`=1; stalls while `busy[15]` (set by a prior call) is 1.
- **Backpressure**: hold `ex_ready`=0 for 3 cycles with 2 instructions queued.
  - `ex_instr` stays stable.
  - `in_ready`=0 once the slot is full.
  - No instruction is lost or duplicated.
- **Flush**: assert `flush` with the slot and execute register both FULL and `ex_ready`=0.
  - Next cycle both are EMPTY and `busy` is unchanged.
  - Repeat with `ex_ready`=1: `busy[dst]` is set.
- **Set/clear collision and reset**:
  - A `wb` clear and an execute set on r3 in the same cycle: `busy[3]`=1.
  - Asserting `reset` mid-stall zeroes all outputs before the next clock edge.
